// File: rtl/ins_mem_pkg.sv
// rtl/ins_mem_pkg.sv - shared types and constants for the instruction memory controller
//
// Purpose: controller state enum, NOP fetch word and default geometry.
// Ports: none (package).
// Build option: IMEM_CHECKSUM_EN (consumed by ins_mem_ctrl).
package ins_mem_pkg;

  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_AW    = 8;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ins_mem_if.sv
// rtl/ins_mem_if.sv - loader byte stream and CPU fetch bus of the instruction memory
//
// Purpose: bundles the loader handshake, the fetch port and the status flags.
// Signals:
//   load_start  loader -> ctrl  one-cycle pulse that starts a load
//   byte_valid  loader -> ctrl  byte valid
//   byte_data   loader -> ctrl  byte value
//   byte_last   loader -> ctrl  final byte of the stream
//   byte_ready  ctrl -> loader  controller accepts a byte
//   IAddr       cpu -> ctrl     fetch byte address
//   IDataOut    ctrl -> cpu     big-endian instruction word
//   cpu_hold    ctrl -> cpu     stall PC / commit
//   load_done   ctrl -> loader  one-cycle pulse on successful load
//   load_err    ctrl -> loader  sticky load error
//   fetch_fault ctrl -> cpu     misaligned or out-of-range fetch
// Modports: master (loader + CPU side), slave (controller side).
interface ins_mem_if;

  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] IAddr;
  logic [31:0] IDataOut;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic        fetch_fault;

  modport master (
    output load_start, byte_valid, byte_data, byte_last, IAddr,
    input  byte_ready, IDataOut, cpu_hold, load_done, load_err, fetch_fault
  );

  modport slave (
    input  load_start, byte_valid, byte_data, byte_last, IAddr,
    output byte_ready, IDataOut, cpu_hold, load_done, load_err, fetch_fault
  );

endinterface

// File: rtl/ins_mem_bytes.sv
// rtl/ins_mem_bytes.sv - byte RAM with one write port and a 4-byte big-endian read port
//
// Purpose: instruction storage; contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable (one byte per cycle)
//   waddr_i  write byte address, must be < DEPTH when we_i=1
//   wdata_i  write byte
//   raddr_i  read byte address of the most significant byte
//   rdata_o  {ram[a], ram[a+1], ram[a+2], ram[a+3]}, combinational
module ins_mem_bytes #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Lanes past the end of the array read as zero so a non-power-of-two
  // DEPTH never indexes outside the storage; the controller masks these
  // words with fetch_fault anyway.
  for (genvar k = 0; k < 4; k++) begin : g_rd
    logic [AW:0] idx;
    assign idx = {1'b0, raddr_i} + (AW+1)'(k);
    assign rdata_o[31-8*k -: 8] = (idx < (AW+1)'(DEPTH)) ? mem_q[idx[AW-1:0]] : 8'h00;
  end

endmodule

// File: rtl/ins_mem_ctrl.sv
// rtl/ins_mem_ctrl.sv - boot-load controller and fetch front-end of the instruction memory
//
// Purpose: loads a byte stream into the instruction RAM, holds the CPU until
// the load completes and serves combinational big-endian 32-bit fetches.
// Ports:
//   CLK    clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    ins_mem_if.slave: loader handshake, fetch port, status flags
// Build option: IMEM_CHECKSUM_EN - final byte is an 8-bit sum of the
// preceding bytes, checked instead of stored.
module ins_mem_ctrl
  import ins_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic       CLK,
  input  logic       Reset,
  ins_mem_if.slave   bus
);

  state_e      state_q, state_d;
  logic [AW:0] wptr_q, wptr_d;   // one extra bit so wptr can reach DEPTH
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        we;
  logic        accept;
  logic        full;
  logic [31:0] rdata;
  logic        fault;

`ifdef IMEM_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  assign accept = bus.byte_valid && (state_q == ST_LOAD);
  assign full   = (wptr_q == (AW+1)'(DEPTH));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    we      = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    // load_start wins over a byte offered in the same cycle
    if (bus.load_start) begin
      state_d = ST_LOAD;
      wptr_d  = '0;
      err_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
      sum_d   = 8'h00;
`endif
    end else if (accept) begin
`ifdef IMEM_CHECKSUM_EN
      if (bus.byte_last) begin
        // the checksum byte itself is never stored
        if (sum_q == bus.byte_data) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end else if (full) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        we     = 1'b1;
        wptr_d = wptr_q + 1'b1;
        sum_d  = sum_q + bus.byte_data;
      end
`else
      if (full) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        we     = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (bus.byte_last) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
`endif
    end
  end

  ins_mem_bytes #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bytes (
    .clk_i   (CLK),
    .we_i    (we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.byte_data),
    .raddr_i (bus.IAddr[AW-1:0]),
    .rdata_o (rdata)
  );

  assign fault = (bus.IAddr[1:0] != 2'b00) || (bus.IAddr > 32'(DEPTH - 4));

  assign bus.byte_ready  = (state_q == ST_LOAD);
  assign bus.cpu_hold    = (state_q != ST_RUN);
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.fetch_fault = fault;
  assign bus.IDataOut    = fault ? NOP_WORD : rdata;

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// tb/tb_ins_mem_ctrl.sv - self-checking bench for ins_mem_ctrl
module tb_ins_mem_ctrl;
  import ins_mem_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  ins_mem_if bus_a ();
  ins_mem_if bus_b ();

  ins_mem_ctrl #(.DEPTH(256), .AW(8)) u_dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_a.slave)
  );

  ins_mem_ctrl #(.DEPTH(8), .AW(3)) u_small (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] word_of(input int a);
    return {byte_of(a), byte_of(a + 1), byte_of(a + 2), byte_of(a + 3)};
  endfunction

  task automatic start(input bit sel);
    if (sel) bus_b.load_start = 1'b1; else bus_a.load_start = 1'b1;
    cyc();
    bus_a.load_start = 1'b0;
    bus_b.load_start = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit last);
    int n = 0;
    while (!(sel ? bus_b.byte_ready : bus_a.byte_ready) && n < 16) begin
      cyc();
      n++;
    end
    chk("byte_ready_wait", 32'(sel ? bus_b.byte_ready : bus_a.byte_ready), 32'd1);
    if (sel) begin
      bus_b.byte_valid = 1'b1; bus_b.byte_data = d; bus_b.byte_last = last;
    end else begin
      bus_a.byte_valid = 1'b1; bus_a.byte_data = d; bus_a.byte_last = last;
    end
    cyc();
    bus_a.byte_valid = 1'b0; bus_a.byte_last = 1'b0;
    bus_b.byte_valid = 1'b0; bus_b.byte_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sum;

    vecs[0]  = '{32'd0,          word_of(0),   1'b0};
    vecs[1]  = '{32'd4,          word_of(4),   1'b0};
    vecs[2]  = '{32'd2,          NOP_WORD,     1'b1};
    vecs[3]  = '{32'd1,          NOP_WORD,     1'b1};
    vecs[4]  = '{32'd3,          NOP_WORD,     1'b1};
    vecs[5]  = '{32'd252,        word_of(252), 1'b0};
    vecs[6]  = '{32'd256,        NOP_WORD,     1'b1};
    vecs[7]  = '{32'd253,        NOP_WORD,     1'b1};
    vecs[8]  = '{32'd248,        word_of(248), 1'b0};
    vecs[9]  = '{32'hFFFF_FFFC,  NOP_WORD,     1'b1};
    vecs[10] = '{32'd128,        word_of(128), 1'b0};

    bus_a.load_start = 0; bus_a.byte_valid = 0; bus_a.byte_data = 0; bus_a.byte_last = 0; bus_a.IAddr = 0;
    bus_b.load_start = 0; bus_b.byte_valid = 0; bus_b.byte_data = 0; bus_b.byte_last = 0; bus_b.IAddr = 0;

    // reset state
    Reset = 1'b0;
    repeat (3) cyc();
    chk("rst_hold",  32'(bus_a.cpu_hold),   32'd1);
    chk("rst_ready", 32'(bus_a.byte_ready), 32'd0);
    chk("rst_err",   32'(bus_a.load_err),   32'd0);
    chk("rst_done",  32'(bus_a.load_done),  32'd0);
    chk("rst_hold_small", 32'(bus_b.cpu_hold), 32'd1);
    Reset = 1'b1;
    cyc();

    // first load
    start(0);
    chk("ready_after_start", 32'(bus_a.byte_ready), 32'd1);
    chk("hold_in_load",      32'(bus_a.cpu_hold),   32'd1);
`ifndef IMEM_CHECKSUM_EN
    send(0, 8'h20, 0); send(0, 8'h01, 0); send(0, 8'h00, 0);
    chk("no_early_done", 32'(bus_a.load_done), 32'd0);
    send(0, 8'h05, 1);
    chk("done_pulse", 32'(bus_a.load_done), 32'd1);
    chk("hold_run",   32'(bus_a.cpu_hold),  32'd0);
    bus_a.IAddr = 0; #1;
    chk("word0", bus_a.IDataOut, 32'h2001_0005);
    chk("word0_fault", 32'(bus_a.fetch_fault), 32'd0);
    cyc();
    chk("done_cleared", 32'(bus_a.load_done), 32'd0);
`else
    send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 0);
    send(0, 8'h0A, 1);
    chk("ck_done",  32'(bus_a.load_done), 32'd1);
    chk("ck_hold",  32'(bus_a.cpu_hold),  32'd0);
    bus_a.IAddr = 0; #1;
    chk("ck_word0", bus_a.IDataOut, 32'h0102_0304);
    start(0);
    send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 0);
    send(0, 8'h0B, 1);
    chk("ck_bad_err",   32'(bus_a.load_err),   32'd1);
    chk("ck_bad_hold",  32'(bus_a.cpu_hold),   32'd1);
    chk("ck_bad_done",  32'(bus_a.load_done),  32'd0);
    chk("ck_bad_ready", 32'(bus_a.byte_ready), 32'd0);
    start(0);
    chk("ck_err_cleared", 32'(bus_a.load_err), 32'd0);
`endif

    // full-depth load, then table-driven fetch checks
    start(0);
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
`ifdef IMEM_CHECKSUM_EN
      send(0, byte_of(i), 0);
`else
      send(0, byte_of(i), i == 255);
`endif
      sum = sum + byte_of(i);
    end
`ifdef IMEM_CHECKSUM_EN
    send(0, sum, 1);
`endif
    chk("full_done", 32'(bus_a.load_done), 32'd1);
    chk("full_hold", 32'(bus_a.cpu_hold),  32'd0);
    for (int v = 0; v < 11; v++) begin
      bus_a.IAddr = vecs[v].addr;
      #1;
      chk($sformatf("fetch_data[%0d]", v),  bus_a.IDataOut,           vecs[v].data);
      chk($sformatf("fetch_fault[%0d]", v), 32'(bus_a.fetch_fault),   32'(vecs[v].fault));
    end

    // load_start and a byte in the same cycle: byte dropped, pointer at 0
    bus_a.IAddr = 0;
    bus_a.load_start = 1'b1; bus_a.byte_valid = 1'b1; bus_a.byte_data = 8'h77;
    cyc();
    bus_a.load_start = 1'b0; bus_a.byte_valid = 1'b0;
    chk("preempt_hold",  32'(bus_a.cpu_hold),   32'd1);
    chk("preempt_ready", 32'(bus_a.byte_ready), 32'd1);
    chk("preempt_nowr",  bus_a.IDataOut, word_of(0));
    send(0, 8'h11, 0);
    chk("preempt_addr0", bus_a.IDataOut, {8'h11, byte_of(1), byte_of(2), byte_of(3)});
    // restart during LOAD
    start(0);
    send(0, 8'h22, 0);
    send(0, 8'h33, 0);
    chk("restart_addr01", bus_a.IDataOut, {8'h22, 8'h33, byte_of(2), byte_of(3)});

    // overflow on the DEPTH=8 instance
    start(1);
    for (int i = 0; i < 9; i++) begin
`ifdef IMEM_CHECKSUM_EN
      send(1, 8'hB0 + 8'(i), 0);
`else
      send(1, 8'hB0 + 8'(i), i == 8);
`endif
    end
    chk("ovf_err",   32'(bus_b.load_err),   32'd1);
    chk("ovf_hold",  32'(bus_b.cpu_hold),   32'd1);
    chk("ovf_ready", 32'(bus_b.byte_ready), 32'd0);
    chk("ovf_done",  32'(bus_b.load_done),  32'd0);
    bus_b.IAddr = 0; #1;
    chk("ovf_w0", bus_b.IDataOut, 32'hB0B1_B2B3);
    bus_b.IAddr = 4; #1;
    chk("ovf_w4", bus_b.IDataOut, 32'hB4B5_B6B7);
    bus_b.IAddr = 8; #1;
    chk("ovf_a8_fault", 32'(bus_b.fetch_fault), 32'd1);
    chk("ovf_a8_nop",   bus_b.IDataOut, NOP_WORD);
    cyc();
    chk("ovf_err_sticky", 32'(bus_b.load_err), 32'd1);
    start(1);
    chk("err_clear_on_start", 32'(bus_b.load_err), 32'd0);

    // asynchronous reset aborts a load in progress
    send(1, 8'hC0, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_abort_ready", 32'(bus_b.byte_ready), 32'd0);
    chk("rst_abort_hold",  32'(bus_b.cpu_hold),   32'd1);
    bus_b.IAddr = 0; #1;
    chk("rst_keeps_ram", bus_b.IDataOut, 32'hC0B1_B2B3);
    Reset = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
